// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART host-command deframer.
// CRC helper is only referenced when UART_CMD_CRC8_EN is defined.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    HUNT,
    OPCODE,
    LENGTH,
    PAYLOAD,
    CHECK,
    EMIT_HDR,
    EMIT_PL
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_CHECKSUM = 2'd1;
  localparam logic [1:0] ERR_LENGTH   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam logic [7:0] CRC8_POLY         = 8'h07;

  // Byte-at-a-time CRC-8, MSB first, no reflection, no final XOR.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_cmd_payload_buf.sv
// Payload staging RAM: one synchronous write port, one asynchronous read port
// so the read data tracks the read pointer within the same cycle.
module uart_cmd_payload_buf #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_cmd_parser.sv
// Deframes SYNC/OPCODE/LEN/payload/CHECK commands popped from the UART RX FIFO.
// Define UART_CMD_CRC8_EN to use CRC-8 (poly 0x07) instead of the XOR checksum.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD    = 64,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1_085_000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        rx_read,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_valid,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_opcode,
  output logic [7:0]  cmd_len,
  output logic        pl_valid,
  input  logic        pl_ready,
  output logic [7:0]  pl_data,
  output logic        pl_last,
  output logic        err_pulse,
  output logic [1:0]  err_code,
  output logic [15:0] frame_count
);

  localparam int unsigned PW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int unsigned TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  MAX_LEN = 8'(MAX_PAYLOAD);

  state_t          r_state;
  logic            r_pending;
  logic            r_rx_read;
  logic [7:0]      r_opcode;
  logic [7:0]      r_len;
  logic [7:0]      r_chk;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [TW-1:0]   r_timer;
  logic            r_cmd_valid;
  logic            r_pl_valid;
  logic            r_pl_last;
  logic            r_err_pulse;
  logic [1:0]      r_err_code;
  logic [15:0]     r_frame_count;

  logic            w_timed;
  logic            w_fetch;
  logic            w_accept;
  logic            w_timeout;
  logic            w_buf_we;
  logic [7:0]      w_rd_data;
  logic [7:0]      w_chk_first;
  logic [7:0]      w_chk_next;

  assign w_timed   = (r_state == OPCODE) || (r_state == LENGTH) ||
                     (r_state == PAYLOAD) || (r_state == CHECK);
  assign w_fetch   = w_timed || (r_state == HUNT);
  assign w_accept  = rx_data_valid && r_pending;
  assign w_timeout = w_timed && !w_accept && (r_timer == TW'(TIMEOUT_CYCLES - 1));
  assign w_buf_we  = (r_state == PAYLOAD) && w_accept;

`ifdef UART_CMD_CRC8_EN
  assign w_chk_first = crc8_update(8'h00, rx_data);
  assign w_chk_next  = crc8_update(r_chk, rx_data);
`else
  assign w_chk_first = rx_data;
  assign w_chk_next  = r_chk ^ rx_data;
`endif

  uart_cmd_payload_buf #(
    .DEPTH(MAX_PAYLOAD),
    .AW   (PW)
  ) u_buf (
    .i_clk  (clock),
    .i_we   (w_buf_we),
    .i_waddr(r_wr_ptr),
    .i_wdata(rx_data),
    .i_raddr(r_rd_ptr),
    .o_rdata(w_rd_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= HUNT;
      r_pending     <= 1'b0;
      r_rx_read     <= 1'b0;
      r_opcode      <= '0;
      r_len         <= '0;
      r_chk         <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_timer       <= '0;
      r_cmd_valid   <= 1'b0;
      r_pl_valid    <= 1'b0;
      r_pl_last     <= 1'b0;
      r_err_pulse   <= 1'b0;
      r_err_code    <= ERR_NONE;
      r_frame_count <= '0;
    end else begin
      r_rx_read   <= 1'b0;
      r_err_pulse <= 1'b0;

      // A read left pending by a timeout still completes; its byte lands in HUNT.
      if (w_fetch && !r_pending) begin
        r_rx_read <= 1'b1;
        r_pending <= 1'b1;
      end else if (rx_data_valid) begin
        r_pending <= 1'b0;
      end

      if (w_timed)               r_timer <= w_accept ? '0 : r_timer + TW'(1);
      else if (r_state == HUNT)  r_timer <= '0;

      if (w_timeout) begin
        r_err_pulse <= 1'b1;
        r_err_code  <= ERR_TIMEOUT;
        r_state     <= HUNT;
      end else begin
        case (r_state)
          HUNT: begin
            if (w_accept && rx_data == SYNC_BYTE) r_state <= OPCODE;
          end
          OPCODE: begin
            if (w_accept) begin
              r_opcode <= rx_data;
              r_chk    <= w_chk_first;
              r_state  <= LENGTH;
            end
          end
          LENGTH: begin
            if (w_accept) begin
              r_len <= rx_data;
              r_chk <= w_chk_next;
              if (rx_data > MAX_LEN) begin
                r_err_pulse <= 1'b1;
                r_err_code  <= ERR_LENGTH;
                r_state     <= HUNT;
              end else if (rx_data == 8'd0) begin
                r_state <= CHECK;
              end else begin
                r_wr_ptr <= '0;
                r_state  <= PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            if (w_accept) begin
              r_wr_ptr <= r_wr_ptr + PW'(1);
              r_chk    <= w_chk_next;
              if (8'(r_wr_ptr) == r_len - 8'd1) r_state <= CHECK;
            end
          end
          CHECK: begin
            if (w_accept) begin
              if (rx_data == r_chk) begin
                r_cmd_valid <= 1'b1;
                r_state     <= EMIT_HDR;
              end else begin
                r_err_pulse <= 1'b1;
                r_err_code  <= ERR_CHECKSUM;
                r_state     <= HUNT;
              end
            end
          end
          EMIT_HDR: begin
            if (cmd_ready) begin
              r_cmd_valid <= 1'b0;
              if (r_len == 8'd0) begin
                r_frame_count <= r_frame_count + 16'd1;
                r_state       <= HUNT;
              end else begin
                r_rd_ptr   <= '0;
                r_pl_valid <= 1'b1;
                r_pl_last  <= (r_len == 8'd1);
                r_state    <= EMIT_PL;
              end
            end
          end
          EMIT_PL: begin
            if (pl_ready) begin
              if (r_pl_last) begin
                r_pl_valid    <= 1'b0;
                r_pl_last     <= 1'b0;
                r_frame_count <= r_frame_count + 16'd1;
                r_state       <= HUNT;
              end else begin
                r_rd_ptr  <= r_rd_ptr + PW'(1);
                r_pl_last <= (8'(r_rd_ptr) + 8'd2 == r_len);
              end
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  assign rx_read     = r_rx_read;
  assign cmd_valid   = r_cmd_valid;
  assign cmd_opcode  = r_opcode;
  assign cmd_len     = r_len;
  assign pl_valid    = r_pl_valid;
  assign pl_data     = r_pl_valid ? w_rd_data : '0;
  assign pl_last     = r_pl_last;
  assign err_pulse   = r_err_pulse;
  assign err_code    = r_err_code;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: FIFO responder model, scoreboard
// queues for header/payload/error outputs, table of frames plus corner sequences.
module tb_uart_cmd_parser;

  localparam int unsigned MAXP = 64;
  localparam int unsigned TMO  = 200;

  logic        clock;
  logic        reset_n;
  logic        rx_read;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode;
  logic [7:0]  cmd_len;
  logic        pl_valid;
  logic        pl_ready;
  logic [7:0]  pl_data;
  logic        pl_last;
  logic        err_pulse;
  logic [1:0]  err_code;
  logic [15:0] frame_count;

  uart_cmd_parser #(
    .MAX_PAYLOAD   (MAXP),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .rx_read      (rx_read),
    .rx_data      (rx_data),
    .rx_data_valid(rx_data_valid),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_opcode   (cmd_opcode),
    .cmd_len      (cmd_len),
    .pl_valid     (pl_valid),
    .pl_ready     (pl_ready),
    .pl_data      (pl_data),
    .pl_last      (pl_last),
    .err_pulse    (err_pulse),
    .err_code     (err_code),
    .frame_count  (frame_count)
  );

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] len;
  } cmd_t;

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  len;
    logic [7:0]  seed;
    bit          bad;
    int unsigned junk;
    logic [1:0]  exp_err;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          ready_mode = 0;
  int          last_valid_cyc = 0;
  int          err_cyc = 0;
  logic [15:0] exp_frames = '0;
  logic [1:0]  exp_code   = '0;

  logic [7:0]  rx_q[$];
  cmd_t        exp_cmd[$];
  logic [8:0]  exp_pl[$];
  logic [1:0]  exp_err[$];

  vec_t        tbl[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected output 0x%0h, nothing expected (cycle %0d)", name, act, cyc);
  endtask

  function automatic logic [7:0] pl_byte(input logic [7:0] seed, input int unsigned i);
    return seed + 8'(i * 17);
  endfunction

  function automatic logic [7:0] fold(input logic [7:0] c, input logic [7:0] b);
`ifdef UART_CMD_CRC8_EN
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int k = 7; k >= 0; k--) begin
      fb = r[7] ^ b[k];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
`else
    return c ^ b;
`endif
  endfunction

  function automatic logic [7:0] frame_chk(input logic [7:0] op, input logic [7:0] len,
                                           input logic [7:0] seed);
    logic [7:0] c;
    c = fold(8'h00, op);
    c = fold(c, len);
    for (int unsigned i = 0; i < len; i++) c = fold(c, pl_byte(seed, i));
    return c;
  endfunction

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  // RX FIFO responder: answers each rx_read after 1..3 cycles once a byte is queued.
  initial begin
    int dly;
    bit busy;
    busy = 1'b0;
    dly = 0;
    rx_data_valid = 1'b0;
    rx_data = '0;
    forever begin
      @(negedge clock);
      rx_data_valid = 1'b0;
      if (!reset_n) begin
        busy = 1'b0;
      end else if (busy) begin
        if (dly > 1) begin
          dly--;
        end else if (rx_q.size() > 0) begin
          rx_data = rx_q.pop_front();
          rx_data_valid = 1'b1;
          last_valid_cyc = cyc;
          busy = 1'b0;
        end
      end else if (rx_read) begin
        busy = 1'b1;
        dly = int'($urandom_range(1, 3));
      end
    end
  end

  initial begin
    cmd_ready = 1'b0;
    pl_ready  = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (ready_mode == 1) begin
        cmd_ready = 1'b1;
        pl_ready  = 1'b0;
      end else begin
        cmd_ready = ($urandom_range(0, 3) != 0);
        pl_ready  = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Output monitor: scoreboard pops, stall stability, error pulse width.
  initial begin
    logic       cst;
    logic       pst;
    logic       pe;
    cmd_t       pcmd;
    logic [8:0] ppl;
    cst = 1'b0;
    pst = 1'b0;
    pe  = 1'b0;
    pcmd = '0;
    ppl = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        cst = 1'b0;
        pst = 1'b0;
        pe  = 1'b0;
      end else begin
        if (cst) check("cmd_stable", {cmd_valid, cmd_opcode, cmd_len}, {1'b1, pcmd});
        if (pst) check("pl_stable", {pl_valid, pl_last, pl_data}, {1'b1, ppl});
        if (cmd_valid && cmd_ready) begin
          if (exp_cmd.size() == 0) unexpected("cmd_hdr", {cmd_opcode, cmd_len});
          else check("cmd_hdr", {cmd_opcode, cmd_len}, exp_cmd.pop_front());
        end
        if (pl_valid && pl_ready) begin
          if (exp_pl.size() == 0) unexpected("pl_beat", {pl_last, pl_data});
          else check("pl_beat", {pl_last, pl_data}, exp_pl.pop_front());
        end
        if (err_pulse) begin
          if (pe) unexpected("err_pulse_width", err_code);
          else if (exp_err.size() == 0) unexpected("err_code", err_code);
          else check("err_code", err_code, exp_err.pop_front());
          err_cyc = cyc;
        end
        pe   = err_pulse;
        cst  = cmd_valid && !cmd_ready;
        pcmd = {cmd_opcode, cmd_len};
        pst  = pl_valid && !pl_ready;
        ppl  = {pl_last, pl_data};
      end
    end
  end

  task automatic push_vec(input vec_t v);
    logic [7:0] good;
    logic [7:0] b;
    for (int unsigned j = 0; j < v.junk; j++) rx_q.push_back(8'(j * 49));
    rx_q.push_back(8'hA5);
    rx_q.push_back(v.op);
    rx_q.push_back(v.len);
    if (v.len <= 8'(MAXP)) begin
      for (int unsigned i = 0; i < v.len; i++) rx_q.push_back(pl_byte(v.seed, i));
      good = frame_chk(v.op, v.len, v.seed);
      b = v.bad ? ((good == 8'h00) ? 8'h01 : 8'h00) : good;
      rx_q.push_back(b);
    end
    if (v.exp_err != 2'd0) begin
      exp_err.push_back(v.exp_err);
      exp_code = v.exp_err;
    end else begin
      exp_cmd.push_back(cmd_t'({v.op, v.len}));
      for (int unsigned i = 0; i < v.len; i++)
        exp_pl.push_back({(i == 32'(v.len) - 1), pl_byte(v.seed, i)});
      exp_frames++;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((rx_q.size() + exp_cmd.size() + exp_pl.size() + exp_err.size()) != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(name, rx_q.size() + exp_cmd.size() + exp_pl.size() + exp_err.size(), 0);
    repeat (4) @(negedge clock);
    check({name, "_frames"}, frame_count, exp_frames);
    check({name, "_errcode"}, err_code, exp_code);
  endtask

  initial begin
    vec_t v;
    int   n;

    tbl[0]  = '{8'h10, 8'd2,   8'h11, 1'b0, 0, 2'd0};
    tbl[1]  = '{8'h10, 8'd2,   8'h11, 1'b1, 0, 2'd1};
    tbl[2]  = '{8'h05, 8'd0,   8'h00, 1'b0, 2, 2'd0};
    tbl[3]  = '{8'h07, 8'd65,  8'h00, 1'b0, 0, 2'd2};
    tbl[4]  = '{8'h33, 8'd4,   8'h01, 1'b0, 1, 2'd0};
    tbl[5]  = '{8'hFF, 8'd1,   8'hAA, 1'b0, 0, 2'd0};
    tbl[6]  = '{8'h44, 8'd64,  8'h3C, 1'b0, 0, 2'd0};
    tbl[7]  = '{8'h20, 8'd3,   8'h90, 1'b1, 0, 2'd1};
    tbl[8]  = '{8'h66, 8'd0,   8'h00, 1'b1, 0, 2'd1};
    tbl[9]  = '{8'h12, 8'd255, 8'h00, 1'b0, 0, 2'd2};
    tbl[10] = '{8'h9A, 8'd63,  8'h5F, 1'b0, 3, 2'd0};

    reset_n = 1'b0;
    ready_mode = 0;
    @(negedge clock);
    check("reset_outputs",
          {rx_read, cmd_valid, cmd_opcode, cmd_len, pl_valid, pl_data, pl_last,
           err_pulse, err_code, frame_count}, 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Literal frame with precomputed XOR check 0x21.
    rx_q.push_back(8'hA5); rx_q.push_back(8'h10); rx_q.push_back(8'h02);
    rx_q.push_back(8'h11); rx_q.push_back(8'h22); rx_q.push_back(8'h21);
`ifdef UART_CMD_CRC8_EN
    exp_err.push_back(2'd1);
    exp_code = 2'd1;
    wait_drain("lit_xor_rejected", 2000);
    v = '{8'h10, 8'd2, 8'h11, 1'b0, 0, 2'd0};
    push_vec(v);
    wait_drain("lit_crc", 2000);
`else
    exp_cmd.push_back(cmd_t'(16'h1002));
    exp_pl.push_back(9'h011);
    exp_pl.push_back(9'h122);
    exp_frames++;
    wait_drain("lit_xor", 2000);
`endif

    for (int unsigned t = 0; t < 11; t++) begin
      push_vec(tbl[t]);
      wait_drain($sformatf("vec%0d", t), 3000);
    end

    // Stall inside a frame until the inter-byte timer expires.
    rx_q.push_back(8'hA5);
    rx_q.push_back(8'h30);
    exp_err.push_back(2'd3);
    exp_code = 2'd3;
    wait_drain("timeout", TMO + 200);
    check("timeout_latency", err_cyc - last_valid_cyc, TMO + 1);
    rx_q.push_back(8'h00);
    rx_q.push_back(8'hFF);
    push_vec(tbl[4]);
    wait_drain("after_timeout", 2000);

    // Consumer backpressure for far longer than the timeout.
    ready_mode = 1;
    push_vec(tbl[0]);
    n = 0;
    while (!pl_valid && n < 500) begin
      @(negedge clock);
      n++;
    end
    check("hold_pl_seen", pl_valid, 1'b1);
    repeat (1000) @(negedge clock);
    check("hold_pl_data", {pl_valid, pl_last, pl_data}, {1'b1, 1'b0, 8'h11});
    check("hold_no_timeout", err_code, exp_code);
    ready_mode = 0;
    wait_drain("hold", 2000);

    // Asynchronous reset in the middle of a payload.
    rx_q.push_back(8'hA5); rx_q.push_back(8'h40); rx_q.push_back(8'h04);
    rx_q.push_back(8'h01); rx_q.push_back(8'h02);
    n = 0;
    while (rx_q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("partial_consumed", rx_q.size(), 0);
    repeat (3) @(negedge clock);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {rx_read, cmd_valid, cmd_opcode, cmd_len, pl_valid, pl_data, pl_last,
           err_pulse, err_code, frame_count}, 64'd0);
    rx_q.delete();
    exp_frames = '0;
    exp_code = '0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    v = tbl[4];
    v.junk = 3;
    push_vec(v);
    wait_drain("post_reset", 2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
